// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, signed or unsigned.
// One quotient bit per CALC cycle; done/busy are registered, so they
// trail the FSM state by one cycle.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t          state, next_state;
    logic [CW-1:0]   cnt;

    // Datapath working registers (no reset: only meaningful while busy)
    logic [WIDTH-1:0] rem_acc;   // partial remainder
    logic [WIDTH-1:0] dq;        // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0] dsr;       // divisor magnitude
    logic             q_neg;
    logic             r_neg;

    logic             is_zero;
    logic             is_ovf;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Two's-complement negate
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + ONE;
    endfunction

    // Negate only when the sign flag says so
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic en);
        return en ? negate(v) : v;
    endfunction

    assign is_zero = (divisor == '0);
    assign is_ovf  = is_signed && (dividend == MIN_VAL) && (divisor == ALL_ONES);
    assign a_neg   = is_signed & dividend[WIDTH-1];
    assign b_neg   = is_signed & divisor[WIDTH-1];

    // One restoring step: bring in the next dividend bit and trial-subtract
    assign shifted = {rem_acc, dq[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr};

    // State register plus registered handshake outputs and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (state == CALC) || (state == FIX);
            done  <= (state == DONE);
            if (state == IDLE)
                cnt <= CW'(WIDTH - 1);
            else if (state == CALC)
                cnt <= cnt - CW'(1);
        end
    end

    // Next-state logic; exceptions skip straight to DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (is_zero || is_ovf) ? DONE : CALC;
            CALC: if (cnt == '0) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture and the shift/subtract iteration
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    dq      <= cond_negate(dividend, a_neg);
                    dsr     <= cond_negate(divisor, b_neg);
                    rem_acc <= '0;
                    q_neg   <= a_neg ^ b_neg;
                    r_neg   <= a_neg;
                end
            end
            CALC: begin
                rem_acc <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                dq      <= {dq[WIDTH-2:0], ~trial[WIDTH]};
            end
            default: ;
        endcase
    end

    // Result/flag registers: fast-path results at acceptance, sign fix-up in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (state == IDLE && start) begin
            div_by_zero <= is_zero;
            overflow    <= is_ovf;
            if (is_zero) begin
                quotient  <= ALL_ONES;
                remainder <= dividend;
            end else if (is_ovf) begin
                quotient  <= MIN_VAL;
                remainder <= '0;
            end
        end else if (state == FIX) begin
            quotient  <= cond_negate(dq, q_neg);
            remainder <= cond_negate(rem_acc, r_neg);
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32): hand-computed vectors,
// latency/busy timing, ignored start while busy, and mid-operation reset.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_vec = 0;
    int n_mis = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one division and check results; inj>0 fires a stray start at that CALC cycle
    task automatic run_div(input string tag, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input logic eov,
                           input int elat, input int inj);
        int cyc;
        int bcnt;
        logic seen;
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; is_signed = ~sgn; dividend = 32'hDEADBEEF; divisor = 32'h00000003;
        cyc = 0; bcnt = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
            else if (inj != 0 && cyc == inj) begin
                start = 1'b1; is_signed = 1'b0;
                dividend = 32'h00000005; divisor = 32'h00000001;
            end
        end
        chk({tag, "_done"}, seen, 1'b1);
        chk({tag, "_lat"}, cyc, elat);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, edz);
        chk({tag, "_ovf"}, overflow, eov);
        if (elat == 34) chk({tag, "_busy"}, bcnt, 33);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, done, 1'b0);
    endtask

    // Start 100/7, then reset at CALC cycle 15 and make sure nothing completes
    task automatic run_reset_abort();
        int dcnt;
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstab_q", quotient, 32'h0);
        chk("rstab_r", remainder, 32'h0);
        chk("rstab_flags", {div_by_zero, overflow}, 2'b00);
        chk("rstab_busy_done", {busy, done}, 2'b00);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("rstab_nodone", dcnt, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", quotient, 32'h0);
        chk("rst_r", remainder, 32'h0);
        chk("rst_flags", {div_by_zero, overflow}, 2'b00);
        chk("rst_busy_done", {busy, done}, 2'b00);
        rst = 1'b0;
        @(posedge clk); #1;

        run_div("u100_7",   1'b0, 32'd100,      32'd7,        32'h0000000E, 32'h00000002, 0, 0, 34, 0);
        run_div("s-7_2",    1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 34, 0);
        run_div("s7_-2",    1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 0, 0, 34, 0);
        run_div("s-100_7",  1'b1, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0, 34, 0);
        run_div("umax_1",   1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0, 0, 34, 0);
        run_div("umin_m1",  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0, 34, 0);
        run_div("sovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0, 1, 1, 0);
        run_div("udz",      1'b0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1, 0, 1, 0);
        run_div("sdz",      1'b1, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1, 0, 1, 0);
        run_div("smin_2",   1'b1, 32'h80000000, 32'h00000002, 32'hC0000000, 32'h00000000, 0, 0, 34, 0);
        run_div("ignstart", 1'b0, 32'd1000,     32'd10,       32'h00000064, 32'h00000000, 0, 0, 34, 10);
        run_div("u1234_0x100", 1'b0, 32'h00001234, 32'h00000100, 32'h00000012, 32'h00000034, 0, 0, 34, 0);

        run_reset_abort();
        run_div("post_rst", 1'b0, 32'd100,      32'd7,        32'h0000000E, 32'h00000002, 0, 0, 34, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
